// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  localparam int unsigned INSTR_W              = 16;
  localparam int unsigned IMM_FLAG_BIT_DEFAULT = 15;

  // Two-bit encoding leaves spare codes; the FSM steers them back to FETCH_OP.
  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_stage_if.sv
// Loader, hazard-control and IF/ID signals of the fetch stage.
interface instr_fetch_stage_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
);
  logic                 load_en;
  logic [ADDR_W-1:0]    load_addr;
  logic [INSTR_W-1:0]   load_data;
  logic                 stall;
  logic                 redirect;
  logic [ADDR_W-1:0]    redirect_pc;
  logic [INSTR_W-1:0]   if_instr;
  logic [INSTR_W-1:0]   if_imm;
  logic [ADDR_W-1:0]    if_pc;
  logic                 if_valid;
  logic [ADDR_W-1:0]    pc;

  modport master (
    input  load_en, load_addr, load_data, stall, redirect, redirect_pc,
    output if_instr, if_imm, if_pc, if_valid, pc
  );

  modport slave (
    output load_en, load_addr, load_data, stall, redirect, redirect_pc,
    input  if_instr, if_imm, if_pc, if_valid, pc
  );
endinterface

// File: rtl/instr_mem.sv
// Instruction memory: synchronous write port for the loader, asynchronous read for fetch.
module instr_mem
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [INSTR_W-1:0]  wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [INSTR_W-1:0]  rdata
);
  logic [INSTR_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, one/two-word instruction assembly FSM and the IF/ID register.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned IMM_FLAG_BIT = IMM_FLAG_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_stage_if.master  bus
);
  fetch_state_t         state_q, state_n;
  logic [ADDR_W-1:0]    pc_q, pc_n, op_pc_q, op_pc_n, if_pc_q, if_pc_n;
  logic [INSTR_W-1:0]   op_hold_q, op_hold_n, if_instr_q, if_instr_n;
  logic [INSTR_W-1:0]   if_imm_q, if_imm_n, fetch_word;
  logic                 if_valid_q, if_valid_n;

  instr_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (bus.load_en),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (pc_q),
    .rdata (fetch_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH_OP;
      pc_q       <= ADDR_W'(RESET_PC);
      op_hold_q  <= '0;
      op_pc_q    <= '0;
      if_instr_q <= '0;
      if_imm_q   <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      op_hold_q  <= op_hold_n;
      op_pc_q    <= op_pc_n;
      if_instr_q <= if_instr_n;
      if_imm_q   <= if_imm_n;
      if_pc_q    <= if_pc_n;
      if_valid_q <= if_valid_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    op_hold_n  = op_hold_q;
    op_pc_n    = op_pc_q;
    if_instr_n = if_instr_q;
    if_imm_n   = if_imm_q;
    if_pc_n    = if_pc_q;
    if_valid_n = if_valid_q;

    // Redirect outranks stall; the IF/ID payload is kept, only its valid bit drops.
    if (bus.redirect) begin
      pc_n       = bus.redirect_pc;
      state_n    = FETCH_OP;
      if_valid_n = 1'b0;
    end else if (!bus.stall) begin
      unique case (state_q)
        FETCH_OP: begin
          pc_n = pc_q + ADDR_W'(1);
          if (fetch_word[IMM_FLAG_BIT]) begin
            op_hold_n  = fetch_word;
            op_pc_n    = pc_q;
            if_valid_n = 1'b0;
            state_n    = FETCH_IMM;
          end else begin
            if_instr_n = fetch_word;
            if_imm_n   = '0;
            if_pc_n    = pc_q;
            if_valid_n = 1'b1;
          end
        end
        FETCH_IMM: begin
          if_instr_n = op_hold_q;
          if_imm_n   = fetch_word;
          if_pc_n    = op_pc_q;
          if_valid_n = 1'b1;
          pc_n       = pc_q + ADDR_W'(1);
          state_n    = FETCH_OP;
        end
        default: begin
          state_n    = FETCH_OP;
          if_valid_n = 1'b0;
        end
      endcase
    end
  end

  assign bus.if_instr = if_instr_q;
  assign bus.if_imm   = if_imm_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_valid = if_valid_q;
  assign bus.pc       = pc_q;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench: directed programs push expected IF/ID words, monitors compare emitted ones.
module tb_instr_fetch_stage;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  exp_t exp4_q[$];

  always #5 clk = ~clk;

  instr_fetch_stage_if #(.ADDR_W(10)) bus ();
  instr_fetch_stage_if #(.ADDR_W(4))  bus4 ();

  instr_fetch_stage #(.ADDR_W(10), .RESET_PC(0)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  instr_fetch_stage #(.ADDR_W(4), .RESET_PC(15)) dut4 (
    .clk   (clk),
    .reset (rst4),
    .bus   (bus4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [9:0] addr, input logic [15:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    step();
    bus.load_en   = 1'b0;
  endtask

  task automatic load4(input logic [3:0] addr, input logic [15:0] data);
    bus4.load_en   = 1'b1;
    bus4.load_addr = addr;
    bus4.load_data = data;
    step();
    bus4.load_en   = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_if_instr"}, 32'(bus.if_instr), 0);
    chk({tag, "_if_imm"},   32'(bus.if_imm),   0);
    chk({tag, "_if_pc"},    32'(bus.if_pc),    0);
    chk({tag, "_if_valid"}, 32'(bus.if_valid), 0);
    chk({tag, "_pc"},       32'(bus.pc),       0);
  endtask

  // An emitted instruction is a valid IF/ID word after an edge that was not reset, stall or redirect.
  always begin
    logic s_rst, s_stall, s_redir;
    exp_t e;
    @(posedge clk);
    s_rst = rst; s_stall = bus.stall; s_redir = bus.redirect;
    #1;
    if (!s_rst && !s_stall && !s_redir && bus.if_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_instr: got=%0h expected none", bus.if_instr);
      end else begin
        e = exp_q.pop_front();
        chk("if_instr", 32'(bus.if_instr), e.instr);
        chk("if_imm",   32'(bus.if_imm),   e.imm);
        chk("if_pc",    32'(bus.if_pc),    e.pc);
      end
    end
  end

  always begin
    logic s_rst, s_stall, s_redir;
    exp_t e;
    @(posedge clk);
    s_rst = rst4; s_stall = bus4.stall; s_redir = bus4.redirect;
    #1;
    if (!s_rst && !s_stall && !s_redir && bus4.if_valid === 1'b1) begin
      if (exp4_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_instr4: got=%0h expected none", bus4.if_instr);
      end else begin
        e = exp4_q.pop_front();
        chk("w4_if_instr", 32'(bus4.if_instr), e.instr);
        chk("w4_if_imm",   32'(bus4.if_imm),   e.imm);
        chk("w4_if_pc",    32'(bus4.if_pc),    e.pc);
      end
    end
  end

  initial begin
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus4.load_en = 1'b0; bus4.load_addr = '0; bus4.load_data = '0;
    bus4.stall = 1'b0; bus4.redirect = 1'b0; bus4.redirect_pc = '0;

    // Straight-line one-word program loaded under reset
    load(10'd0, 16'h1001);
    load(10'd1, 16'h1002);
    load(10'd2, 16'h1003);
    chk_zero_outputs("reset");
    exp_q.push_back(exp_t'{32'h1001, 0, 0});
    exp_q.push_back(exp_t'{32'h1002, 0, 1});
    exp_q.push_back(exp_t'{32'h1003, 0, 2});
    rst = 1'b0;
    repeat (3) step();
    chk("seq_pc_end", 32'(bus.pc), 3);
    rst = 1'b1;

    // Two-word program (plus words for later phases), loaded under reset
    load(10'd0, 16'h8005);
    load(10'd1, 16'h00AB);
    load(10'd2, 16'h1000);
    load(10'd3, 16'h8777);
    load(10'd4, 16'h0042);
    load(10'h010, 16'h1234);
    exp_q.push_back(exp_t'{32'h8005, 32'h00AB, 0});
    exp_q.push_back(exp_t'{32'h1000, 0, 2});
    rst = 1'b0;
    step();
    chk("two_bubble_valid", 32'(bus.if_valid), 0);
    chk("two_bubble_pc", 32'(bus.pc), 1);
    step();
    step();
    chk("two_pc_end", 32'(bus.pc), 3);
    rst = 1'b1;
    step();

    // Stall while waiting for the immediate
    exp_q.push_back(exp_t'{32'h8005, 32'h00AB, 0});
    rst = 1'b0;
    step();
    bus.stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(bus.pc), 1);
      chk("stall_valid", 32'(bus.if_valid), 0);
    end
    bus.stall = 1'b0;
    step();
    chk("stall_pc_after", 32'(bus.pc), 2);
    rst = 1'b1;
    step();

    // Redirect beats a simultaneous stall in FETCH_IMM
    exp_q.push_back(exp_t'{32'h1234, 0, 32'h010});
    rst = 1'b0;
    step();
    bus.redirect = 1'b1; bus.redirect_pc = 10'h010; bus.stall = 1'b1;
    step();
    chk("redir_pc", 32'(bus.pc), 32'h010);
    chk("redir_valid", 32'(bus.if_valid), 0);
    bus.redirect = 1'b0; bus.stall = 1'b0;
    step();
    chk("redir_pc_after", 32'(bus.pc), 32'h011);
    rst = 1'b1;
    step();

    // Reset in the middle of a two-word fetch, then full re-fetch
    exp_q.push_back(exp_t'{32'h8005, 32'h00AB, 0});
    exp_q.push_back(exp_t'{32'h1000, 0, 2});
    rst = 1'b0;
    repeat (4) step();
    chk("mid_pc", 32'(bus.pc), 4);
    chk("mid_valid", 32'(bus.if_valid), 0);
    chk("mid_instr_held", 32'(bus.if_instr), 32'h1000);
    rst = 1'b1;
    step();
    chk_zero_outputs("midrst");
    exp_q.push_back(exp_t'{32'h8005, 32'h00AB, 0});
    exp_q.push_back(exp_t'{32'h1000, 0, 2});
    exp_q.push_back(exp_t'{32'h8777, 32'h0042, 3});
    rst = 1'b0;
    repeat (5) step();
    chk("refetch_pc", 32'(bus.pc), 5);
    rst = 1'b1;
    step();

    // PC wrap on a 16-word memory starting at the last address
    load4(4'd15, 16'h8001);
    load4(4'd0,  16'h0077);
    chk("w4_reset_pc", 32'(bus4.pc), 15);
    exp4_q.push_back(exp_t'{32'h8001, 32'h0077, 15});
    rst4 = 1'b0;
    step();
    chk("w4_wrap_pc", 32'(bus4.pc), 0);
    chk("w4_bubble", 32'(bus4.if_valid), 0);
    step();
    chk("w4_pc_after", 32'(bus4.pc), 1);
    rst4 = 1'b1;
    repeat (2) step();

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("scoreboard4_drained", 32'(exp4_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
